// File: rtl/mem_pingpong_ctrl.sv
// mem_pingpong_ctrl: ping/pong bank sequencer for the transpose buffers.
// It owns bank occupancy, generates write bank/address/sub-word for each beat,
// and hands full banks to the reader one address per accepted read.
// Optional build macro: MEM_PP_STALL_CNT_EN adds a saturating stall_cnt output.
module mem_pingpong_ctrl #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned log2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [log2_DEPTH-1:0] num_of_dat,
  input  logic                  rank_mode,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic                  wen,
  output logic                  wbank,
  output logic [log2_DEPTH-1:0] waddr,
  output logic [1:0]            word_addr,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  rbank,
  output logic [log2_DEPTH-1:0] raddr,
`ifdef MEM_PP_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  done
);

  localparam int unsigned AW = log2_DEPTH;

  // Depth and address width must describe the same bank size.
  if (MEM_DEPTH != (32'd1 << AW)) begin : g_depth_check
    $error("mem_pingpong_ctrl: MEM_DEPTH must equal 2**log2_DEPTH");
  end

  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [1:0]    wsub;
  logic [AW-1:0] len [2];
  logic [1:0]    mode;

  logic          first_beat;
  logic [AW-1:0] cur_len;
  logic          cur_mode;
  logic          wr_last;
  logic          rd_fire;
  logic          rd_last;

  // Handshake and address outputs follow the bank state directly.
  assign in_rdy    = ~full[wr_ptr];
  assign wen       = in_vld & in_rdy;
  assign wbank     = wr_ptr;
  assign waddr     = wr_cnt;
  assign word_addr = wsub;
  assign out_vld   = full[rd_ptr];
  assign rbank     = rd_ptr;
  assign raddr     = rd_cnt;

  // The first beat of a bank uses the live config, later beats the latched one.
  always_comb begin
    first_beat = (wr_cnt == '0) && (wsub == 2'd0);
    cur_len    = first_beat ? num_of_dat : len[wr_ptr];
    cur_mode   = first_beat ? rank_mode  : mode[wr_ptr];
    wr_last    = (wr_cnt == cur_len) && (!cur_mode || (wsub == 2'd3));
    rd_fire    = out_vld & out_rdy;
    rd_last    = (rd_cnt == len[rd_ptr]);
  end

  // Occupancy update: write-set and read-clear always land on different banks.
  always_comb begin
    full_nxt = full;
    if (wen && wr_last) full_nxt[wr_ptr] = 1'b1;
    if (rd_fire && rd_last) full_nxt[rd_ptr] = 1'b0;
  end

  // Bank occupancy, write-side sequencing and per-bank config capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 2'b00;
      wr_ptr <= 1'b0;
      wr_cnt <= '0;
      wsub   <= 2'd0;
      len[0] <= '0;
      len[1] <= '0;
      mode   <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wen) begin
        if (first_beat) begin
          len[wr_ptr]  <= num_of_dat;
          mode[wr_ptr] <= rank_mode;
        end
        if (wr_last) begin
          wr_ptr <= ~wr_ptr;
          wr_cnt <= '0;
          wsub   <= 2'd0;
        end else if (cur_mode) begin
          wsub <= wsub + 2'd1;
          if (wsub == 2'd3) wr_cnt <= wr_cnt + AW'(1);
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
    end
  end

  // Read-side address sequencing and end-of-bank pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      rd_cnt <= '0;
      done   <= 1'b0;
    end else begin
      done <= rd_fire && rd_last;
      if (rd_fire) begin
        if (rd_last) begin
          rd_ptr <= ~rd_ptr;
          rd_cnt <= '0;
        end else begin
          rd_cnt <= rd_cnt + AW'(1);
        end
      end
    end
  end

`ifdef MEM_PP_STALL_CNT_EN
  // Saturating count of cycles where a beat is offered but refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (in_vld && !in_rdy && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_pingpong_ctrl.sv
// Bench for mem_pingpong_ctrl: a per-cycle vector table plus hand sequences
// for stalls, config change mid-bank and reset during operation.
module tb_mem_pingpong_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] num_of_dat;
  logic       rank_mode;
  logic       in_vld;
  logic       in_rdy;
  logic       wen;
  logic       wbank;
  logic [3:0] waddr;
  logic [1:0] word_addr;
  logic       out_vld;
  logic       out_rdy;
  logic       rbank;
  logic [3:0] raddr;
  logic       done;
`ifdef MEM_PP_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  mem_pingpong_ctrl #(.MEM_DEPTH(16), .log2_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .num_of_dat(num_of_dat), .rank_mode(rank_mode),
    .in_vld(in_vld), .in_rdy(in_rdy), .wen(wen), .wbank(wbank),
    .waddr(waddr), .word_addr(word_addr), .out_vld(out_vld),
    .out_rdy(out_rdy), .rbank(rbank), .raddr(raddr),
`ifdef MEM_PP_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       ordy;
    logic [3:0] nod;
    logic       rm;
    logic       e_irdy;
    logic       e_wen;
    logic       e_wb;
    logic [3:0] e_wa;
    logic [1:0] e_ws;
    logic       e_ov;
    logic       e_rb;
    logic [3:0] e_ra;
    logic       e_dn;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];
  int   nfill = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int r, input int iv, input int ordy, input int nod, input int rm,
                     input int irdy, input int w, input int wb, input int wa, input int ws,
                     input int ov, input int rb, input int ra, input int dn);
    vec_t v;
    v.rst = 1'(r); v.iv = 1'(iv); v.ordy = 1'(ordy); v.nod = 4'(nod); v.rm = 1'(rm);
    v.e_irdy = 1'(irdy); v.e_wen = 1'(w); v.e_wb = 1'(wb); v.e_wa = 4'(wa);
    v.e_ws = 2'(ws); v.e_ov = 1'(ov); v.e_rb = 1'(rb); v.e_ra = 4'(ra); v.e_dn = 1'(dn);
    tbl[nfill] = v;
    nfill++;
  endtask

  // Drive inputs just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic iv, input logic ordy,
                       input logic [3:0] nod, input logic rm);
    @(negedge clk);
    rst = r; in_vld = iv; out_rdy = ordy; num_of_dat = nod; rank_mode = rm;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; num_of_dat = 4'd0; rank_mode = 1'b0;

    // rst iv or nod rm | irdy wen wb wa ws ov rb ra dn
    add(1,0,0,3,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,3,0, 1,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,1,0,3,0, 1,1,0,k,0,0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,0,1,3,0, 1,0,1,0,0,1,0,k,0);
    add(0,0,1,3,0, 1,0,1,0,0,0,1,0,1);
    add(0,0,0,3,0, 1,0,1,0,0,0,1,0,0);
    add(1,0,0,1,1, 0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 8; k++) add(0,1,0,1,1, 1,1,0,k/4,k%4,0,0,0,0);
    add(0,0,1,1,1, 1,0,1,0,0,1,0,0,0);
    add(0,0,1,1,1, 1,0,1,0,0,1,0,1,0);
    add(0,0,0,1,1, 1,0,1,0,0,0,1,0,1);
    add(0,1,0,0,0, 1,1,1,0,0,0,1,0,0);
    add(0,1,1,0,0, 1,1,0,0,0,1,1,0,0);
    add(0,0,1,0,0, 1,0,1,0,0,1,0,0,1);
    add(0,0,0,0,0, 1,0,1,0,0,0,1,0,1);
    add(0,0,0,0,0, 1,0,1,0,0,0,1,0,0);

    for (int i = 0; i < nfill; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].ordy, tbl[i].nod, tbl[i].rm);
      if (!tbl[i].rst) begin
        chk($sformatf("v%0d in_rdy", i),    int'(in_rdy),    int'(tbl[i].e_irdy));
        chk($sformatf("v%0d wen", i),       int'(wen),       int'(tbl[i].e_wen));
        chk($sformatf("v%0d wbank", i),     int'(wbank),     int'(tbl[i].e_wb));
        chk($sformatf("v%0d waddr", i),     int'(waddr),     int'(tbl[i].e_wa));
        chk($sformatf("v%0d word_addr", i), int'(word_addr), int'(tbl[i].e_ws));
        chk($sformatf("v%0d out_vld", i),   int'(out_vld),   int'(tbl[i].e_ov));
        chk($sformatf("v%0d rbank", i),     int'(rbank),     int'(tbl[i].e_rb));
        chk($sformatf("v%0d raddr", i),     int'(raddr),     int'(tbl[i].e_ra));
        chk($sformatf("v%0d done", i),      int'(done),      int'(tbl[i].e_dn));
      end
    end

    // Backpressure: both banks fill, beats 9..12 are refused, then bank 0 drains.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
      chk($sformatf("stall beat%0d in_rdy", i), int'(in_rdy), (i < 8) ? 1 : 0);
      chk($sformatf("stall beat%0d wen", i),    int'(wen),    (i < 8) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
`ifdef MEM_PP_STALL_CNT_EN
    chk("stall_cnt after 4", int'(stall_cnt), 4);
`endif
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drive(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
      chk($sformatf("drain%0d raddr", k),  int'(raddr),  k);
      chk($sformatf("drain%0d rbank", k),  int'(rbank),  0);
      chk($sformatf("drain%0d in_rdy", k), int'(in_rdy), 0);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    chk("drain done",    int'(done),    1);
    chk("drain in_rdy",  int'(in_rdy),  1);
    chk("drain out_vld", int'(out_vld), 1);
    chk("drain rbank",   int'(rbank),   1);
`ifdef MEM_PP_STALL_CNT_EN
    chk("stall_cnt hold", int'(stall_cnt), 4);
`endif

    // Config change after bank 0's first beat only affects bank 1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i == 0) ? 4'd3 : 4'd1, 1'b0);
      chk($sformatf("cfg beat%0d wbank", i), int'(wbank), (i < 4) ? 0 : 1);
      chk($sformatf("cfg beat%0d waddr", i), int'(waddr), (i < 4) ? i : i - 4);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    chk("cfg both full in_rdy", int'(in_rdy), 0);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) drive(1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
      else begin out_rdy = 1'b1; #1; end
      chk($sformatf("cfg rd%0d out_vld", c), int'(out_vld), (c < 6) ? 1 : 0);
      chk($sformatf("cfg rd%0d done", c),    int'(done),    (c == 4 || c == 6) ? 1 : 0);
      if (c < 6) begin
        chk($sformatf("cfg rd%0d rbank", c), int'(rbank), (c < 4) ? 0 : 1);
        chk($sformatf("cfg rd%0d raddr", c), int'(raddr), (c < 4) ? c : c - 4);
      end
    end

    // Reset while bank 0 drains and bank 1 is half written.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
      chk($sformatf("mid%0d waddr", i), int'(waddr), i);
      chk($sformatf("mid%0d raddr", i), int'(raddr), i);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    chk("rst out_vld", int'(out_vld), 0);
    chk("rst in_rdy",  int'(in_rdy),  1);
    chk("rst waddr",   int'(waddr),   0);
    chk("rst done",    int'(done),    0);
    chk("rst raddr",   int'(raddr),   0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
    chk("post-rst wen",   int'(wen),   1);
    chk("post-rst wbank", int'(wbank), 0);
    chk("post-rst waddr", int'(waddr), 0);
    @(negedge clk);
    in_vld = 1'b0;
    chk("post-rst waddr next", int'(waddr), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
